// File: rtl/chf_pkg.sv
// Shared definitions for the PLL management responder: register map,
// NTSC reset settings and the controller state encoding.
package chf_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    LOAD,
    BUSY,
    DONE
  } state_t;

  localparam logic [5:0] ADDR_MODE   = 6'd0;
  localparam logic [5:0] ADDR_STATUS = 6'd1;
  localparam logic [5:0] ADDR_START  = 6'd2;
  localparam logic [5:0] ADDR_N      = 6'd3;
  localparam logic [5:0] ADDR_M      = 6'd4;
  localparam logic [5:0] ADDR_C0     = 6'd5;
  localparam logic [5:0] ADDR_MFRAC  = 6'd7;
  // Setting bit 5 selects the active copy instead of the shadow copy
  localparam logic [5:0] ADDR_ACTIVE = 6'd32;

  localparam logic [31:0] RST_N     = 32'h0001_0000;
  localparam logic [31:0] RST_M     = 32'h0000_0404;
  localparam logic [31:0] RST_C0    = 32'h0000_0505;
  localparam logic [31:0] RST_MFRAC = 32'h9745_BF27;

  function automatic logic [31:0] status_word(input logic ready, input logic err);
    return {30'd0, err, ready};
  endfunction

endpackage

// File: rtl/chf_pll_mgmt_resp_if.sv
// Memory-mapped management bus between a host (master) and the PLL
// management responder (slave).
interface chf_pll_mgmt_resp_if;
  logic        mgmt_write;
  logic        mgmt_read;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic [31:0] mgmt_readdata;
  logic        mgmt_waitrequest;

  modport master (
    output mgmt_write, mgmt_read, mgmt_address, mgmt_writedata,
    input  mgmt_readdata, mgmt_waitrequest
  );

  modport slave (
    input  mgmt_write, mgmt_read, mgmt_address, mgmt_writedata,
    output mgmt_readdata, mgmt_waitrequest
  );
endinterface

// File: rtl/chf_busy_timer.sv
// Down-counter that measures the emulated lock/reconfiguration time;
// shared by the INIT and BUSY phases of the controller.
module chf_busy_timer #(
  parameter int unsigned CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam logic [7:0] START_VAL = 8'(CYCLES - 1);

  logic [7:0] count;

  // Reset preloads the count so INIT is timed without an explicit load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= START_VAL;
    end else if (load) begin
      count <= START_VAL;
    end else if (en && count != 8'd0) begin
      count <= count - 8'd1;
    end
  end

  assign done = (count == 8'd0);

endmodule

// File: rtl/chf_pll_mgmt_resp.sv
// PLL reconfiguration management responder: shadow registers, START-driven
// apply sequence and emulated lock. Optional CHF_PLL_READBACK_EN enables readback.
module chf_pll_mgmt_resp
  import chf_pkg::*;
#(
  parameter int unsigned BUSY_CYCLES = 16
) (
  input  logic                 mgmt_clk,
  input  logic                 mgmt_reset,
  chf_pll_mgmt_resp_if.slave   bus,
  output logic [31:0]          cfg_n,
  output logic [31:0]          cfg_m,
  output logic [31:0]          cfg_c0,
  output logic [31:0]          cfg_mfrac,
  output logic                 reconfig_strobe,
  output logic                 locked
);

  state_t      state, state_nxt;
  logic        mode, err;
  logic [31:0] shadow_n, shadow_m, shadow_c0, shadow_mfrac;
  logic [31:0] rd_mux;
  logic        busy_st, ready, timer_load, timer_en, timer_done;
  logic        wr_acc, wr_drop, rd_acc, start_acc;

  chf_busy_timer #(.CYCLES(BUSY_CYCLES)) u_timer (
    .clk  (mgmt_clk),
    .rst  (mgmt_reset),
    .load (timer_load),
    .en   (timer_en),
    .done (timer_done)
  );

  // Writes only take effect when ready; otherwise they stall or are dropped by mode
  assign wr_acc    = bus.mgmt_write && ready;
  assign wr_drop   = bus.mgmt_write && busy_st && mode;
  assign rd_acc    = bus.mgmt_read && !bus.mgmt_write && !bus.mgmt_waitrequest;
  assign start_acc = wr_acc && (bus.mgmt_address == ADDR_START);

  always_ff @(posedge mgmt_clk or posedge mgmt_reset) begin
    if (mgmt_reset) state <= INIT;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (timer_done) state_nxt = IDLE;
      IDLE:    if (start_acc) state_nxt = LOAD;
      LOAD:    state_nxt = BUSY;
      BUSY:    if (timer_done) state_nxt = DONE;
      DONE:    state_nxt = start_acc ? LOAD : IDLE;
      default: state_nxt = INIT;
    endcase
  end

  always_comb begin
    busy_st              = (state == INIT) || (state == LOAD) || (state == BUSY);
    ready                = (state == IDLE) || (state == DONE);
    locked               = ready;
    reconfig_strobe      = (state == LOAD);
    timer_load           = (state == LOAD);
    timer_en             = (state == INIT) || (state == BUSY);
    bus.mgmt_waitrequest = !mode && busy_st && (bus.mgmt_write || bus.mgmt_read);
  end

  always_ff @(posedge mgmt_clk or posedge mgmt_reset) begin
    if (mgmt_reset) begin
      mode         <= 1'b0;
      shadow_n     <= RST_N;
      shadow_m     <= RST_M;
      shadow_c0    <= RST_C0;
      shadow_mfrac <= RST_MFRAC;
    end else if (wr_acc) begin
      case (bus.mgmt_address)
        ADDR_MODE:  mode         <= bus.mgmt_writedata[0];
        ADDR_N:     shadow_n     <= bus.mgmt_writedata;
        ADDR_M:     shadow_m     <= bus.mgmt_writedata;
        ADDR_C0:    shadow_c0    <= bus.mgmt_writedata;
        ADDR_MFRAC: shadow_mfrac <= bus.mgmt_writedata;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge mgmt_clk or posedge mgmt_reset) begin
    if (mgmt_reset)                                     err <= 1'b0;
    else if (wr_acc && bus.mgmt_address == ADDR_STATUS) err <= 1'b0;
    else if (wr_drop)                                   err <= 1'b1;
  end

  always_ff @(posedge mgmt_clk or posedge mgmt_reset) begin
    if (mgmt_reset) begin
      cfg_n     <= RST_N;
      cfg_m     <= RST_M;
      cfg_c0    <= RST_C0;
      cfg_mfrac <= RST_MFRAC;
    end else if (state == LOAD) begin
      cfg_n     <= shadow_n;
      cfg_m     <= shadow_m;
      cfg_c0    <= shadow_c0;
      cfg_mfrac <= shadow_mfrac;
    end
  end

  always_comb begin
    rd_mux = 32'd0;
    case (bus.mgmt_address)
      ADDR_MODE:   rd_mux = {31'd0, mode};
      ADDR_STATUS: rd_mux = status_word(ready, err);
`ifdef CHF_PLL_READBACK_EN
      ADDR_N:                    rd_mux = shadow_n;
      ADDR_M:                    rd_mux = shadow_m;
      ADDR_C0:                   rd_mux = shadow_c0;
      ADDR_MFRAC:                rd_mux = shadow_mfrac;
      ADDR_N     + ADDR_ACTIVE:  rd_mux = cfg_n;
      ADDR_M     + ADDR_ACTIVE:  rd_mux = cfg_m;
      ADDR_C0    + ADDR_ACTIVE:  rd_mux = cfg_c0;
      ADDR_MFRAC + ADDR_ACTIVE:  rd_mux = cfg_mfrac;
`endif
      default:     rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge mgmt_clk or posedge mgmt_reset) begin
    if (mgmt_reset)  bus.mgmt_readdata <= 32'd0;
    else if (rd_acc) bus.mgmt_readdata <= rd_mux;
  end

endmodule

// File: tb/tb_chf_pll_mgmt_resp.sv
// Directed self-checking bench for chf_pll_mgmt_resp (BUSY_CYCLES = 16);
// readback expectations follow CHF_PLL_READBACK_EN.
module tb_chf_pll_mgmt_resp;

  logic        mgmt_clk = 1'b0;
  logic        mgmt_reset = 1'b1;
  logic [31:0] cfg_n, cfg_m, cfg_c0, cfg_mfrac;
  logic        reconfig_strobe, locked;
  int          compared = 0;
  int          mismatched = 0;
  int          strobe_cnt = 0;
  int          stalls;
  int          low_cycles;
  logic [31:0] rdata;

  chf_pll_mgmt_resp_if bus ();

  chf_pll_mgmt_resp #(.BUSY_CYCLES(16)) dut (
    .mgmt_clk        (mgmt_clk),
    .mgmt_reset      (mgmt_reset),
    .bus             (bus.slave),
    .cfg_n           (cfg_n),
    .cfg_m           (cfg_m),
    .cfg_c0          (cfg_c0),
    .cfg_mfrac       (cfg_mfrac),
    .reconfig_strobe (reconfig_strobe),
    .locked          (locked)
  );

  always #5 mgmt_clk = ~mgmt_clk;

  always @(negedge mgmt_clk) if (reconfig_strobe === 1'b1) strobe_cnt++;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance
  task automatic bus_write(input logic [5:0] addr, input logic [31:0] data,
                           output int n_stall);
    bus.mgmt_address   = addr;
    bus.mgmt_writedata = data;
    bus.mgmt_write     = 1'b1;
    n_stall = 0;
    #1;
    while (bus.mgmt_waitrequest && n_stall < 200) begin
      n_stall++;
      @(negedge mgmt_clk);
      #1;
    end
    @(negedge mgmt_clk);
    bus.mgmt_write = 1'b0;
  endtask

  task automatic bus_read(input logic [5:0] addr, output logic [31:0] data);
    int n_stall;
    bus.mgmt_address = addr;
    bus.mgmt_read    = 1'b1;
    n_stall = 0;
    #1;
    while (bus.mgmt_waitrequest && n_stall < 200) begin
      n_stall++;
      @(negedge mgmt_clk);
      #1;
    end
    @(negedge mgmt_clk);
    bus.mgmt_read = 1'b0;
    data = bus.mgmt_readdata;
  endtask

  task automatic wait_locked(input string tag);
    int n;
    n = 0;
    while (locked !== 1'b1 && n < 300) begin
      @(negedge mgmt_clk);
      n++;
    end
    check_output(tag, {31'd0, locked}, 32'd1);
  endtask

  initial begin
    bus.mgmt_write     = 1'b0;
    bus.mgmt_read      = 1'b0;
    bus.mgmt_address   = 6'd0;
    bus.mgmt_writedata = 32'd0;
    repeat (3) @(negedge mgmt_clk);

    check_output("rst_cfg_n", cfg_n, 32'h0001_0000);
    check_output("rst_cfg_m", cfg_m, 32'h0000_0404);
    check_output("rst_cfg_c0", cfg_c0, 32'h0000_0505);
    check_output("rst_cfg_mfrac", cfg_mfrac, 32'h9745_BF27);
    check_output("rst_locked", {31'd0, locked}, 32'd0);
    check_output("rst_strobe", {31'd0, reconfig_strobe}, 32'd0);
    check_output("rst_readdata", bus.mgmt_readdata, 32'd0);

    // Lock comes up after the 16-cycle INIT phase
    mgmt_reset = 1'b0;
    low_cycles = 0;
    while (locked !== 1'b1 && low_cycles < 100) begin
      low_cycles++;
      @(negedge mgmt_clk);
    end
    check_output("init_low_cycles", low_cycles, 32'd16);
    check_output("init_cfg_m", cfg_m, 32'h0000_0404);
    bus_read(6'd1, rdata);
    check_output("init_status", rdata, 32'h1);

    // Waitrequest mode: apply new C0/MFRAC, then a write stalls through LOAD+BUSY
    bus_write(6'd5, 32'h0002_0504, stalls);
    check_output("idle_no_stall", stalls, 32'd0);
    bus_write(6'd7, 32'hA3D7_09E8, stalls);
    strobe_cnt = 0;
    bus_write(6'd2, 32'hDEAD_BEEF, stalls);
    bus_write(6'd3, 32'h0003_0000, stalls);
    check_output("busy_stall_cycles", stalls, 32'd17);
    check_output("strobe_once", strobe_cnt, 32'd1);
    check_output("apply_cfg_c0", cfg_c0, 32'h0002_0504);
    check_output("apply_cfg_mfrac", cfg_mfrac, 32'hA3D7_09E8);
    check_output("apply_cfg_n_old", cfg_n, 32'h0001_0000);
    check_output("done_locked", {31'd0, locked}, 32'd1);

    // A stalled START accepted in DONE goes straight to LOAD
    strobe_cnt = 0;
    bus_write(6'd2, 32'd0, stalls);
    bus_write(6'd2, 32'd0, stalls);
    check_output("restart_stall", stalls, 32'd17);
    check_output("restart_strobe", {31'd0, reconfig_strobe}, 32'd1);
    check_output("restart_locked", {31'd0, locked}, 32'd0);
    check_output("restart_cfg_n", cfg_n, 32'h0003_0000);
    wait_locked("restart_lock");
    check_output("restart_strobes", strobe_cnt, 32'd2);

    // Polling mode: writes during BUSY are dropped and flag ERR
    bus_write(6'd0, 32'hFFFF_FFF1, stalls);
    bus_read(6'd0, rdata);
    check_output("mode_read", rdata, 32'h1);
    bus_write(6'd2, 32'd0, stalls);
    repeat (2) @(negedge mgmt_clk);
    bus_write(6'd4, 32'h0000_0505, stalls);
    check_output("poll_no_stall", stalls, 32'd0);
    bus_read(6'd1, rdata);
    check_output("poll_busy_status", rdata, 32'h2);
    wait_locked("poll_lock");
    check_output("poll_cfg_m", cfg_m, 32'h0000_0404);
    bus_read(6'd1, rdata);
    check_output("poll_status_err", rdata, 32'h3);
    bus_write(6'd1, 32'd0, stalls);
    bus_read(6'd1, rdata);
    check_output("err_cleared", rdata, 32'h1);

    // Simultaneous write and read: write wins, readdata holds
    bus_read(6'd6, rdata);
    check_output("unmapped_read", rdata, 32'd0);
    bus.mgmt_read = 1'b1;
    bus_write(6'd3, 32'h0002_0000, stalls);
    bus.mgmt_read = 1'b0;
    check_output("wr_rd_hold", bus.mgmt_readdata, 32'd0);
    bus_write(6'd2, 32'd0, stalls);
    wait_locked("wr_rd_lock");
    check_output("wr_rd_cfg_n", cfg_n, 32'h0002_0000);

    // Reset in the middle of BUSY discards pending settings
    bus_write(6'd3, 32'h0005_0000, stalls);
    bus_write(6'd2, 32'd0, stalls);
    repeat (4) @(negedge mgmt_clk);
    strobe_cnt = 0;
    mgmt_reset = 1'b1;
    #1;
    check_output("abort_cfg_n", cfg_n, 32'h0001_0000);
    check_output("abort_locked", {31'd0, locked}, 32'd0);
    @(negedge mgmt_clk);
    mgmt_reset = 1'b0;
    wait_locked("abort_lock");
    check_output("abort_no_strobe", strobe_cnt, 32'd0);
    check_output("abort_cfg_n_after", cfg_n, 32'h0001_0000);
    bus_read(6'd0, rdata);
    check_output("abort_mode", rdata, 32'd0);

    // Readback of shadow versus active M
    bus_write(6'd4, 32'h1234_5678, stalls);
    bus_read(6'd4, rdata);
`ifdef CHF_PLL_READBACK_EN
    check_output("rb_shadow_m", rdata, 32'h1234_5678);
`else
    check_output("rb_shadow_m", rdata, 32'd0);
`endif
    bus_read(6'd36, rdata);
`ifdef CHF_PLL_READBACK_EN
    check_output("rb_active_m", rdata, 32'h0000_0404);
`else
    check_output("rb_active_m", rdata, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
